// File: rtl/h_alpha_stream_rx.sv
// Captures one H/y frame and one alpha frame into register banks, checks tlast
// framing, and holds the frame for the compute core until it is acknowledged.
module h_alpha_stream_rx #(
   parameter  int J       = 4,
   parameter  int I       = 7,
   parameter  int A       = 4,
   localparam int I_WIDTH = $clog2(I) + 1,
   localparam int J_WIDTH = $clog2(J) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [J*64-1:0]      H_row,
   input  logic [127:0]         y,
   input  logic                 H_row_tvalid,
   input  logic                 H_row_tlast,
   input  logic [A*8-1:0]       alpha_u_col,
   input  logic                 alpha_u_col_tvalid,
   input  logic                 alpha_u_col_tlast,
   output logic                 frame_valid,
   input  logic                 frame_ack,
   input  logic                 rd_en,
   input  logic [I_WIDTH-1:0]   rd_row,
   output logic [J*64-1:0]      rd_h_row,
   output logic [127:0]         rd_y,
   output logic                 rd_valid,
   output logic [J*A*8-1:0]     alpha_all,
   output logic                 err_len,
   output logic                 err_overrun
);

   localparam int ROW_IDX_W = (I > 1) ? $clog2(I) : 1;
   localparam int COL_IDX_W = (J > 1) ? $clog2(J) : 1;

   typedef enum logic [1:0] {IDLE, RX_H, RX_ALPHA, HOLD} state_t;

   state_t              state, next_state;
   logic [I_WIDTH-1:0]  row_cnt;
   logic [J_WIDTH-1:0]  col_cnt;
   logic [J*64-1:0]     h_bank [I];
   logic [127:0]        y_bank [I];
   logic [A*8-1:0]      alpha_bank [J];

   logic h_we, a_we, len_hit, ovr_hit, clr_cnt;
   logic row_at_end, col_at_end;
   logic [ROW_IDX_W-1:0] rd_idx;

   assign row_at_end  = (row_cnt == I_WIDTH'(I - 1));
   assign col_at_end  = (col_cnt == J_WIDTH'(J - 1));
   assign rd_idx      = rd_row[ROW_IDX_W-1:0];
   assign frame_valid = (state == HOLD);

   // IDLE behaves like RX_H with row_cnt at zero, so both share one branch.
   always_comb begin
      next_state = state;
      h_we       = 1'b0;
      a_we       = 1'b0;
      len_hit    = 1'b0;
      ovr_hit    = 1'b0;
      clr_cnt    = 1'b0;
      case (state)
         IDLE, RX_H: begin
            if (H_row_tvalid) begin
               h_we       = 1'b1;
               next_state = (H_row_tlast || row_at_end) ? RX_ALPHA : RX_H;
               len_hit    = (H_row_tlast != row_at_end);
            end
            if (alpha_u_col_tvalid) ovr_hit = 1'b1;
         end
         RX_ALPHA: begin
            if (alpha_u_col_tvalid) begin
               a_we       = 1'b1;
               next_state = (alpha_u_col_tlast || col_at_end) ? HOLD : RX_ALPHA;
               len_hit    = (alpha_u_col_tlast != col_at_end);
            end
            if (H_row_tvalid) ovr_hit = 1'b1;
         end
         HOLD: begin
            if (H_row_tvalid || alpha_u_col_tvalid) ovr_hit = 1'b1;
            if (frame_ack) begin
               next_state = IDLE;
               clr_cnt    = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         row_cnt     <= '0;
         col_cnt     <= '0;
         err_len     <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         state <= next_state;
         if (len_hit) err_len     <= 1'b1;
         if (ovr_hit) err_overrun <= 1'b1;
         if (clr_cnt) begin
            row_cnt <= '0;
            col_cnt <= '0;
         end else begin
            if (h_we) row_cnt <= row_cnt + 1'b1;
            if (a_we) col_cnt <= col_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < I; r++) begin
            h_bank[r] <= '0;
            y_bank[r] <= '0;
         end
         for (int c = 0; c < J; c++) alpha_bank[c] <= '0;
      end else begin
         if (h_we) begin
            h_bank[row_cnt[ROW_IDX_W-1:0]] <= H_row;
            y_bank[row_cnt[ROW_IDX_W-1:0]] <= y;
         end
         if (a_we) alpha_bank[col_cnt[COL_IDX_W-1:0]] <= alpha_u_col;
      end
   end

   // Out-of-range rows still answer, with zero data, so the core never stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_h_row <= '0;
         rd_y     <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en && (rd_row < I_WIDTH'(I))) begin
            rd_h_row <= h_bank[rd_idx];
            rd_y     <= y_bank[rd_idx];
         end else begin
            rd_h_row <= '0;
            rd_y     <= '0;
         end
      end
   end

   for (genvar j = 0; j < J; j++) begin : g_alpha
      assign alpha_all[j*A*8 +: A*8] = alpha_bank[j];
   end

endmodule

// File: tb/tb_h_alpha_stream_rx.sv
// Directed frame sequences with random payloads, checked against a frame-level
// reference model of what the receiver should hold.
module tb_h_alpha_stream_rx;

   localparam int J  = 4;
   localparam int I  = 7;
   localparam int A  = 4;
   localparam int IW = $clog2(I) + 1;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [J*64-1:0]    H_row = '0;
   logic [127:0]       y = '0;
   logic               H_row_tvalid = 1'b0;
   logic               H_row_tlast = 1'b0;
   logic [A*8-1:0]     alpha_u_col = '0;
   logic               alpha_u_col_tvalid = 1'b0;
   logic               alpha_u_col_tlast = 1'b0;
   logic               frame_valid;
   logic               frame_ack = 1'b0;
   logic               rd_en = 1'b0;
   logic [IW-1:0]      rd_row = '0;
   logic [J*64-1:0]    rd_h_row;
   logic [127:0]       rd_y;
   logic               rd_valid;
   logic [J*A*8-1:0]   alpha_all;
   logic               err_len;
   logic               err_overrun;

   h_alpha_stream_rx #(.J(J), .I(I), .A(A)) dut (
      .clk(clk), .rst(rst),
      .H_row(H_row), .y(y), .H_row_tvalid(H_row_tvalid), .H_row_tlast(H_row_tlast),
      .alpha_u_col(alpha_u_col), .alpha_u_col_tvalid(alpha_u_col_tvalid),
      .alpha_u_col_tlast(alpha_u_col_tlast),
      .frame_valid(frame_valid), .frame_ack(frame_ack),
      .rd_en(rd_en), .rd_row(rd_row), .rd_h_row(rd_h_row), .rd_y(rd_y),
      .rd_valid(rd_valid), .alpha_all(alpha_all),
      .err_len(err_len), .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   // Reference model: what the banks and sticky flags should contain.
   logic [J*64-1:0] exp_h [I];
   logic [127:0]    exp_y [I];
   logic [A*8-1:0]  exp_a [J];
   logic            exp_len, exp_ovr;
   logic [J*64-1:0] next_h [I];
   logic [127:0]    next_y [I];
   logic [A*8-1:0]  next_a [J];

   int checks   = 0;
   int failures = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int r = 0; r < I; r++) begin
         exp_h[r] = '0;
         exp_y[r] = '0;
      end
      for (int c = 0; c < J; c++) exp_a[c] = '0;
      exp_len = 1'b0;
      exp_ovr = 1'b0;
   endtask

   task automatic fill_next();
      for (int r = 0; r < I; r++) begin
         for (int k = 0; k < J*2; k++) next_h[r][k*32 +: 32] = $urandom();
         for (int k = 0; k < 4; k++) next_y[r][k*32 +: 32] = $urandom();
      end
      for (int c = 0; c < J; c++) next_a[c] = $urandom();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_frame_valid", 256'(frame_valid), 256'(0));
      check("rst_alpha_all", 256'(alpha_all), 256'(0));
      check("rst_err_len", 256'(err_len), 256'(0));
      check("rst_err_overrun", 256'(err_overrun), 256'(0));
      check("rst_rd_valid", 256'(rd_valid), 256'(0));
      check("rst_rd_h_row", 256'(rd_h_row), 256'(0));
      clear_model();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // n beats sent; store=0 means the beats arrive where they must be dropped.
   task automatic send_h(input int n, input int tlast_at, input bit store);
      for (int b = 0; b < n; b++) begin
         H_row        = next_h[b];
         y            = next_y[b];
         H_row_tvalid = 1'b1;
         H_row_tlast  = (b + 1 == tlast_at);
         tick();
         if (store) begin
            exp_h[b] = next_h[b];
            exp_y[b] = next_y[b];
         end else exp_ovr = 1'b1;
      end
      H_row_tvalid = 1'b0;
      H_row_tlast  = 1'b0;
      if (store && tlast_at != I) exp_len = 1'b1;
   endtask

   task automatic send_alpha(input int n, input int tlast_at, input bit store);
      for (int c = 0; c < n; c++) begin
         alpha_u_col        = next_a[c];
         alpha_u_col_tvalid = 1'b1;
         alpha_u_col_tlast  = (c + 1 == tlast_at);
         if (store) check("fv_before_last_alpha", 256'(frame_valid), 256'(0));
         tick();
         if (store) exp_a[c] = next_a[c];
         else exp_ovr = 1'b1;
      end
      alpha_u_col_tvalid = 1'b0;
      alpha_u_col_tlast  = 1'b0;
      if (store) begin
         if (tlast_at != J) exp_len = 1'b1;
         check("fv_after_last_alpha", 256'(frame_valid), 256'(1));
      end
   endtask

   task automatic check_flags(input string tag);
      logic [J*A*8-1:0] flat;
      for (int c = 0; c < J; c++) flat[c*A*8 +: A*8] = exp_a[c];
      check({tag, "_err_len"}, 256'(err_len), 256'(exp_len));
      check({tag, "_err_overrun"}, 256'(err_overrun), 256'(exp_ovr));
      check({tag, "_alpha_all"}, 256'(alpha_all), 256'(flat));
   endtask

   task automatic read_row(input int r);
      logic [J*64-1:0] eh;
      logic [127:0]    ey;
      eh = '0;
      ey = '0;
      if (r < I) begin
         eh = exp_h[r];
         ey = exp_y[r];
      end
      rd_en  = 1'b1;
      rd_row = IW'(r);
      tick();
      rd_en = 1'b0;
      check($sformatf("rd_valid_row%0d", r), 256'(rd_valid), 256'(1));
      check($sformatf("rd_h_row%0d", r), 256'(rd_h_row), 256'(eh));
      check($sformatf("rd_y_row%0d", r), 256'(rd_y), 256'(ey));
      tick();
      check($sformatf("rd_valid_idle_after%0d", r), 256'(rd_valid), 256'(0));
   endtask

   task automatic read_all();
      for (int r = 0; r < I; r++) read_row(r);
   endtask

   task automatic ack_frame();
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      check("fv_after_ack", 256'(frame_valid), 256'(0));
   endtask

   initial begin
      clear_model();
      #3;
      do_reset();

      // Nominal frame with fixed first row and alpha values
      fill_next();
      next_h[0] = {64'hBFFE54E978512DEF, 64'h3FE4BF0A4395F979,
                   64'h3FEF6A0B2F3143F7, 64'h3FEF5F1F6D3F4D6D};
      next_y[0] = {64'hBFE21B141554CC6F, 64'hC0042CAFE382D2CB};
      next_a[0] = 32'h8D010100;
      next_a[1] = 32'h6FF9FD00;
      next_a[2] = 32'h010501FF;
      next_a[3] = 32'h00000001;
      send_h(I, I, 1'b1);
      check_flags("t1_after_h");
      send_alpha(J, J, 1'b1);
      check("t1_alpha_low", 256'(alpha_all[31:0]), 256'(32'h8D010100));
      check_flags("t1_hold");
      read_all();
      ack_frame();

      // Second frame arrives while the first is held
      fill_next();
      send_h(I, I, 1'b1);
      send_alpha(J, J, 1'b1);
      fill_next();
      send_h(I, I, 1'b0);
      send_alpha(2, 0, 1'b0);
      check_flags("t4_overrun");
      check("t4_still_holding", 256'(frame_valid), 256'(1));
      read_all();
      ack_frame();
      fill_next();
      send_h(I, I, 1'b1);
      send_alpha(J, J, 1'b1);
      check_flags("t4_new_frame");
      read_all();

      // Out-of-range row reads
      read_row(7);
      read_row(15);
      ack_frame();

      // Reset mid-frame, then a clean frame
      fill_next();
      send_h(3, 0, 1'b1);
      do_reset();
      fill_next();
      send_h(I, I, 1'b1);
      send_alpha(J, J, 1'b1);
      check_flags("t6_clean");
      read_all();
      ack_frame();

      // Early H tlast on beat 5
      do_reset();
      fill_next();
      send_h(5, 5, 1'b1);
      check_flags("t2_after_h");
      send_alpha(J, J, 1'b1);
      check_flags("t2_hold");
      read_all();
      ack_frame();

      // Missing alpha tlast
      do_reset();
      fill_next();
      send_h(I, I, 1'b1);
      check_flags("t3_after_h");
      send_alpha(J, 0, 1'b1);
      check_flags("t3_hold");
      ack_frame();

      // Alpha beat in IDLE is dropped and flagged
      do_reset();
      fill_next();
      send_alpha(1, 0, 1'b0);
      check_flags("idle_alpha");
      check("idle_alpha_fv", 256'(frame_valid), 256'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
